sram_responder: RTL and testbench

- Synthesizable behavioural model of the external 16-bit asynchronous SRAM chip: the responder end of the SRAM_* pin interface that the SRAM controller drives.
- Used in simulation and FPGA loopback builds in place of the physical IS61LV25616-style part.
- Stores halfwords with byte lanes and returns read data with a fixed registered latency.
- Provides a reset-time clear sweep, access counters and a sticky protocol-error flag for the testbench.

---
 rtl/sram_responder.sv | 154 +++++++++++++++
 tb/tb_sram_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Behavioural responder for a 16-bit asynchronous SRAM pin interface.
// Byte-lane writes, fixed-latency reads, reset-time clear sweep, counters and a sticky error flag.
module sram_responder #(
  parameter int ADDR_WIDTH     = 18,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [15:0]           SRAM_DQ,
  input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  input  logic                  SRAM_UB_N,
  input  logic                  SRAM_LB_N,
  input  logic                  SRAM_WE_N,
  input  logic                  SRAM_CE_N,
  input  logic                  SRAM_OE_N,
  output logic                  busy,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count,
  output logic                  protocol_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wr_count_q, wr_count_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic              err_q, err_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [15:0]       mem [DEPTH];
  logic [IDX_W-1:0]  addr_idx;
  logic              addr_oor;
  logic              active, access, wr_req, rd_req, pins_read;
  logic              dq_xz;
  logic [15:0]       rd_word;
  logic              mem_we_lo, mem_we_hi;
  logic [IDX_W-1:0]  mem_widx;
  logic [15:0]       mem_wdata;
  logic              dq_en;
  logic [15:0]       dq_out;

  assign addr_idx  = SRAM_ADDR[IDX_W-1:0];
  assign addr_oor  = {1'b0, SRAM_ADDR} >= (ADDR_WIDTH+1)'(DEPTH);
  assign active    = !SRAM_CE_N;
  assign access    = active && (!SRAM_WE_N || !SRAM_OE_N);
  assign pins_read = active && SRAM_WE_N && !SRAM_OE_N;
  assign wr_req    = !busy && active && !SRAM_WE_N;
  assign rd_req    = !busy && pins_read;
  assign rd_word   = mem[addr_idx];

`ifdef SYNTHESIS
  assign dq_xz = 1'b0;
`else
  assign dq_xz = $isunknown(SRAM_DQ);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (idx_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    busy = (state_q == S_CLEAR);
  end

  always_comb begin
    idx_d      = busy ? idx_q + 1'b1 : '0;
    wr_count_d = wr_count_q + 32'(wr_req);
    rd_count_d = rd_count_q + 32'(rd_req);
    err_d      = err_q | (busy & access) | (active & addr_oor) | (wr_req & dq_xz);
    rdata_d    = rd_word;
    rvalid_d   = rd_req;

    // The sweep owns the write port; pin writes are ignored while it runs.
    mem_we_lo = 1'b0;
    mem_we_hi = 1'b0;
    mem_widx  = addr_idx;
    mem_wdata = SRAM_DQ;
    if (busy) begin
      mem_we_lo = 1'b1;
      mem_we_hi = 1'b1;
      mem_widx  = idx_q;
      mem_wdata = 16'h0000;
    end else if (wr_req) begin
      mem_we_lo = !SRAM_LB_N;
      mem_we_hi = !SRAM_UB_N;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // No reset on the array so contents survive reset when no sweep is configured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_we_lo) mem[mem_widx][7:0]  <= mem_wdata[7:0];
      if (mem_we_hi) mem[mem_widx][15:8] <= mem_wdata[15:8];
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign dq_en  = pins_read && !busy;
      assign dq_out = rd_word;
    end else begin : g_lat1
      assign dq_en  = rvalid_q && pins_read;
      assign dq_out = rdata_q;
    end
  endgenerate

  // pins_read requires WE_N high, so the bus is never driven against a write.
  assign SRAM_DQ[15:8] = (dq_en && !SRAM_UB_N) ? dq_out[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (dq_en && !SRAM_LB_N) ? dq_out[7:0]  : 8'hzz;

  assign wr_count     = wr_count_q;
  assign rd_count     = rd_count_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table for the access protocol plus sweep/error sequences.
// Released DQ bits read back as 1 through the bench pull-ups.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] dq;
  logic [17:0] addr = '0;
  logic        ub_n = 1'b1, lb_n = 1'b1, we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
  logic [15:0] tb_dq = '0;
  logic        tb_oe = 1'b0;
  logic        busy, protocol_err;
  logic [31:0] wr_count, rd_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  sram_responder #(
    .ADDR_WIDTH(18), .DEPTH(1024), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count), .protocol_err(protocol_err)
  );

  typedef struct {
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    bit          chk_dq;
    logic [15:0] exp_dq;
    logic [15:0] zmask;
    int          exp_wr, exp_rd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic c, logic w, logic o, logic u, logic l, logic [17:0] a,
                              logic [15:0] d, bit cd, logic [15:0] e, logic [15:0] z,
                              int ew, int er);
    vec_t v;
    v.ce_n = c; v.we_n = w; v.oe_n = o; v.ub_n = u; v.lb_n = l;
    v.addr = a; v.wdata = d; v.chk_dq = cd; v.exp_dq = e; v.zmask = z;
    v.exp_wr = ew; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic pins(input logic c, input logic w, input logic o, input logic u, input logic l,
                      input logic [17:0] a, input logic [15:0] d);
    ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a; tb_dq = d;
    tb_oe = !w;
  endtask

  task automatic idle();
    pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] lo, hi;
    lo = '0;
    hi = '0;

    //        ce we oe ub lb addr  wdata    chk exp      zmask    wr rd
    vecs[0]  = mk(0, 1, 0, 0, 0, 10,  16'h0000, 1, 16'h0000, 16'hFFFF, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 11,  16'h0000, 1, 16'h0000, 16'h0000, 0, 1);
    vecs[2]  = mk(0, 0, 1, 0, 0, 5,   16'hBEEF, 0, 16'h0000, 16'h0000, 0, 2);
    vecs[3]  = mk(0, 1, 0, 0, 0, 5,   16'h0000, 1, 16'h0000, 16'hFFFF, 1, 2);
    vecs[4]  = mk(0, 1, 0, 0, 0, 5,   16'h0000, 1, 16'hBEEF, 16'h0000, 1, 3);
    vecs[5]  = mk(0, 0, 1, 0, 0, 7,   16'h1234, 0, 16'h0000, 16'h0000, 1, 4);
    vecs[6]  = mk(0, 0, 1, 0, 1, 7,   16'hAB00, 0, 16'h0000, 16'h0000, 2, 4);
    vecs[7]  = mk(0, 1, 0, 0, 0, 7,   16'h0000, 1, 16'h0000, 16'hFFFF, 3, 4);
    vecs[8]  = mk(0, 1, 0, 1, 0, 7,   16'h0000, 1, 16'h0034, 16'hFF00, 3, 5);
    vecs[9]  = mk(0, 1, 0, 0, 1, 7,   16'h0000, 1, 16'hAB00, 16'h00FF, 3, 6);
    vecs[10] = mk(0, 0, 1, 0, 0, 300, 16'hF00D, 0, 16'h0000, 16'h0000, 3, 7);
    vecs[11] = mk(0, 0, 1, 0, 0, 301, 16'hCAFE, 0, 16'h0000, 16'h0000, 4, 7);
    vecs[12] = mk(0, 1, 0, 0, 0, 300, 16'h0000, 1, 16'h0000, 16'hFFFF, 5, 7);
    vecs[13] = mk(0, 1, 0, 0, 0, 301, 16'h0000, 1, 16'hF00D, 16'h0000, 5, 8);
    vecs[14] = mk(0, 1, 0, 0, 0, 0,   16'h0000, 1, 16'hCAFE, 16'h0000, 5, 9);
    vecs[15] = mk(0, 0, 1, 1, 1, 5,   16'h0000, 0, 16'h0000, 16'h0000, 5, 10);
    vecs[16] = mk(0, 1, 0, 0, 0, 5,   16'h0000, 1, 16'h0000, 16'hFFFF, 6, 10);
    vecs[17] = mk(0, 1, 0, 0, 0, 5,   16'h0000, 1, 16'hBEEF, 16'h0000, 6, 11);
    vecs[18] = mk(1, 1, 1, 1, 1, 0,   16'h0000, 1, 16'h0000, 16'hFFFF, 6, 12);
    vecs[19] = mk(0, 1, 1, 0, 0, 5,   16'h0000, 1, 16'h0000, 16'hFFFF, 6, 12);
    vecs[20] = mk(1, 1, 1, 1, 1, 0,   16'h0000, 1, 16'h0000, 16'hFFFF, 6, 12);

    // Reset and full sweep
    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr", wr_count, 32'd0);
    chk("rst_rd", rd_count, 32'd0);
    chk("rst_err", 32'(protocol_err), 32'd0);
    chk("rst_dq", 32'(dq), 32'h0000FFFF);
    wait_sweep(n);
    chk("sweep_len", 32'(n), 32'd1024);

    // Access protocol vectors
    for (int i = 0; i < 21; i++) begin
      pins(vecs[i].ce_n, vecs[i].we_n, vecs[i].oe_n, vecs[i].ub_n, vecs[i].lb_n,
           vecs[i].addr, vecs[i].wdata);
      #1;
      if (vecs[i].chk_dq)
        chk($sformatf("v%0d_dq", i), 32'(dq), 32'(vecs[i].exp_dq | vecs[i].zmask));
      chk($sformatf("v%0d_wr", i), wr_count, 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_rd", i), rd_count, 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_err", i), 32'(protocol_err), 32'd0);
      if (i == 13) lo = dq;
      if (i == 14) hi = dq;
      @(negedge clk);
    end
    chk("two_word", {hi, lo}, 32'hCAFEF00D);

    // Write to addr 3 after the sweep has passed it: must be dropped and flagged
    do_reset();
    repeat (100) @(negedge clk);
    pins(0, 0, 1, 0, 0, 18'd3, 16'h7777);
    @(negedge clk);
    idle();
    #1;
    chk("busy_err", 32'(protocol_err), 32'd1);
    chk("busy_wr", wr_count, 32'd0);
    wait_sweep(n);
    pins(0, 1, 0, 0, 0, 18'd3, 16'h0000);
    @(negedge clk);
    #1;
    chk("busy_rd3", 32'(dq), 32'h00000000);
    chk("busy_err_sticky", 32'(protocol_err), 32'd1);
    idle();

    // Out-of-range address wraps onto the array
    do_reset();
    wait_sweep(n);
    #1;
    chk("wrap_err0", 32'(protocol_err), 32'd0);
    pins(0, 0, 1, 0, 0, 18'd1033, 16'h5555);
    @(negedge clk);
    pins(0, 1, 0, 0, 0, 18'd9, 16'h0000);
    #1;
    chk("wrap_err", 32'(protocol_err), 32'd1);
    chk("wrap_wr", wr_count, 32'd1);
    @(negedge clk);
    #1;
    chk("wrap_rd9", 32'(dq), 32'h00005555);
    idle();

    // Reset in mid-sweep restarts it from index 0
    do_reset();
    repeat (500) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep(n);
    chk("restart_len", 32'(n), 32'd1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
